// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared FSM type and sizing constants for fifo_write_arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

  localparam int MAX_NUM_REQ = 8;
  localparam int BURST_CNT_W = $clog2(16) + 1;
  localparam int IDX_W       = $clog2(MAX_NUM_REQ);

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting after last_i
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // last_i itself is searched last, so a lone requester can re-win its own turn
  always_comb begin
    int   cand;
    logic found;
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        win_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin arbiter for the aFifo write port
// Optional burst mode: define FIFO_ARB_BURST_EN to hold a grant for up to MAX_BURST words.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          CLKIN,
  input  logic                          Clear_in,
  input  logic [NUM_REQ-1:0]            Req_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_in,
  output logic [NUM_REQ-1:0]            Ack_out,
  output logic [NUM_REQ-1:0]            Grant_out,
  input  logic                          FifoFull_in,
  output logic [DATA_WIDTH-1:0]         FifoData_out,
  output logic                          FifoWriteEn_out
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
    $error("fifo_write_arbiter: NUM_REQ out of range");
  end
  if (MAX_BURST < 1 || MAX_BURST > (1 << (BURST_CNT_W - 1))) begin : g_bad_max_burst
    $error("fifo_write_arbiter: MAX_BURST out of range");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic               xfer_ok;
  logic [NUM_REQ-1:0] ack_w;
  logic               accepted;
  logic               req_g;
  logic               burst_done;
  logic               release_g;
  logic [IDX_W-1:0]   pick_last;
  logic [NUM_REQ-1:0] pick_win;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  assign xfer_ok   = ~FifoFull_in & ~Clear_in;
  assign ack_w     = grant_q & Req_in & {NUM_REQ{xfer_ok}};
  assign accepted  = |ack_w;
  assign req_g     = |(grant_q & Req_in);
  assign release_g = (state_q == ARB_GRANTED) && (!req_g || burst_done);
  // On release the pointer moves to the current grant before the search
  assign pick_last = (state_q == ARB_GRANTED) ? gidx_q : last_q;

`ifdef FIFO_ARB_BURST_EN
  logic [BURST_CNT_W-1:0] cnt_q, cnt_d;

  assign burst_done = accepted && (cnt_q == BURST_CNT_W'(MAX_BURST - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ARB_IDLE || release_g) begin
      cnt_d = '0;
    end else if (accepted) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLKIN) begin
    if (Clear_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign burst_done = accepted;
`endif

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req_i (Req_in),
    .last_i(pick_last),
    .win_o (pick_win),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_ff @(posedge CLKIN) begin
    if (Clear_in) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_GRANTED;
          grant_d = pick_win;
          gidx_d  = pick_idx;
        end
      end
      ARB_GRANTED: begin
        if (release_g) begin
          last_d = gidx_q;
          if (pick_any) begin
            grant_d = pick_win;
            gidx_d  = pick_idx;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    logic [DATA_WIDTH-1:0] data_mux;
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) data_mux = data_mux | Data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
    Ack_out         = ack_w;
    FifoWriteEn_out = accepted;
    Grant_out       = grant_q;
    FifoData_out    = data_mux;
  end

endmodule
